// File: rtl/fifo_burst_reader.sv
// Read-side burst consumer for the cross-clock FIFO: starts bursts on fill level,
// idle timeout or flush, and re-emits the words as a framed valid/ready stream.
module fifo_burst_reader #(
   parameter int WIDTH        = 16,
   parameter int ADDR_BITS    = 4,
   parameter int READ_LATENCY = 2,
   parameter int BURST_LEN    = 8,
   parameter int TIMEOUT      = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 fifo_rd_en,
   input  logic [WIDTH-1:0]     fifo_rd_data,
   input  logic [ADDR_BITS:0]   fifo_rd_size,
   input  logic                 fifo_rd_empty,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_first,
   output logic                 out_last,
   output logic                 busy
);

   localparam int LW = $clog2(BURST_LEN + 1);
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [ADDR_BITS:0] BL_SIZE = (ADDR_BITS + 1)'(BURST_LEN);
   localparam logic [LW-1:0]      BL_CNT  = LW'(BURST_LEN);
   localparam logic [TW-1:0]      TMO_MAX = TW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t            state, state_n;
   logic [LW-1:0]     rd_left, lat_left, burst_len;
   logic [TW-1:0]     tmo_cnt;
   logic              flush_req;
   logic [2:0]        occ, inflight;
   logic [3:0]        credit;
   logic [1:0]        vld_pipe;
   logic [WIDTH-1:0]  buf_mem [4];
   logic [1:0]        wr_ptr, rd_ptr;
   logic              first_pend;
   logic              fill_trig, tmo_trig, start, push, pop;

   assign credit    = {1'b0, occ} + {1'b0, inflight};
   assign push      = (READ_LATENCY == 1) ? vld_pipe[0] : vld_pipe[1];
   assign out_valid = (occ != 3'd0);
   assign pop       = out_valid && out_ready;
   assign out_data  = buf_mem[rd_ptr];
   assign out_first = out_valid && first_pend;
   assign out_last  = out_valid && (lat_left == LW'(1));
   assign busy      = (state != IDLE);

   always_comb begin
      state_n    = state;
      start      = 1'b0;
      fifo_rd_en = 1'b0;
      fill_trig  = (fifo_rd_size >= BL_SIZE);
      tmo_trig   = (((TIMEOUT != 0) && (tmo_cnt == TMO_MAX)) || flush_req) && !fifo_rd_empty;
      // Fill wins: when it fires the size is already >= BURST_LEN.
      burst_len  = (fill_trig || fifo_rd_size >= BL_SIZE) ? BL_CNT : LW'(fifo_rd_size);
      case (state)
         IDLE: begin
            if (fill_trig || tmo_trig) begin
               start   = 1'b1;
               state_n = READ;
            end
         end
         READ: begin
            fifo_rd_en = (rd_left != '0) && !fifo_rd_empty && (credit < 4'd4);
            if (fifo_rd_en && rd_left == LW'(1)) state_n = DRAIN;
         end
         DRAIN: begin
            if (pop && lat_left == LW'(1)) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_left    <= '0;
         lat_left   <= '0;
         tmo_cnt    <= '0;
         flush_req  <= 1'b0;
         occ        <= '0;
         inflight   <= '0;
         vld_pipe   <= '0;
         buf_mem    <= '{default: '0};
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         first_pend <= 1'b0;
      end else begin
         if (start)           rd_left <= burst_len;
         else if (fifo_rd_en) rd_left <= rd_left - LW'(1);

         if (start)    lat_left <= burst_len;
         else if (pop) lat_left <= lat_left - LW'(1);

         if (start)    first_pend <= 1'b1;
         else if (pop) first_pend <= 1'b0;

         if (fifo_rd_empty || start)                   tmo_cnt <= '0;
         else if (state == IDLE && tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TW'(1);

         // A flush seen while IDLE with nothing to read is dropped.
         if (start || (state == IDLE && fifo_rd_empty)) flush_req <= 1'b0;
         else if (flush)                                flush_req <= 1'b1;

         vld_pipe <= {vld_pipe[0], fifo_rd_en};
         inflight <= inflight + {2'b00, fifo_rd_en} - {2'b00, push};
         occ      <= occ + {2'b00, push} - {2'b00, pop};

         if (push) begin
            buf_mem[wr_ptr] <= fifo_rd_data;
            wr_ptr          <= wr_ptr + 2'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 2'd1;
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: READ_LATENCY=1 and =2 instances share stimulus; each
// has its own FIFO model and a burst-level reference model predicting busy and the stream.
module tb_fifo_burst_reader;

   localparam int W  = 16;
   localparam int AB = 4;
   localparam int BL = 8;
   localparam int TO = 10;

   typedef struct packed { logic [W-1:0] d; logic f; logic l; } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, flush, out_ready;
   logic          rd_en [2], rd_empty [2], ov [2], of [2], ol [2], bz [2];
   logic [W-1:0]  rd_data [2], od [2];
   logic [AB:0]   rd_size [2];

   fifo_burst_reader #(.WIDTH(W), .ADDR_BITS(AB), .READ_LATENCY(1), .BURST_LEN(BL), .TIMEOUT(TO)) u_lat1 (
      .clk(clk), .rst_n(rst_n), .fifo_rd_en(rd_en[0]), .fifo_rd_data(rd_data[0]),
      .fifo_rd_size(rd_size[0]), .fifo_rd_empty(rd_empty[0]), .flush(flush),
      .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
      .out_first(of[0]), .out_last(ol[0]), .busy(bz[0]));

   fifo_burst_reader #(.WIDTH(W), .ADDR_BITS(AB), .READ_LATENCY(2), .BURST_LEN(BL), .TIMEOUT(TO)) u_lat2 (
      .clk(clk), .rst_n(rst_n), .fifo_rd_en(rd_en[1]), .fifo_rd_data(rd_data[1]),
      .fifo_rd_size(rd_size[1]), .fifo_rd_empty(rd_empty[1]), .flush(flush),
      .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
      .out_first(of[1]), .out_last(ol[1]), .busy(bz[1]));

   logic [W-1:0] fq [2][$];
   exp_t         eq [2][$];
   bit           m_busy [2], m_freq [2], m_seen [2], s_busy [2];
   int           m_tmo [2], m_rdleft [2], m_rem [2], m_out [2], m_trig [2], pops [2];
   bit           p_v [2], s_v [2];
   logic [W-1:0] p_w [2], s_w [2];
   int           cyc, vectors, miscompares;
   bit           gap_mode;
   logic [W-1:0] nxt_word;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_fifo();
      for (int i = 0; i < 2; i++) begin
         rd_size[i]  = (AB + 1)'(fq[i].size());
         rd_empty[i] = (fq[i].size() == 0);
      end
   endtask

   task automatic push_word(input logic [W-1:0] w);
      for (int i = 0; i < 2; i++)
         if (fq[i].size() < 16) fq[i].push_back(w);
      drive_fifo();
   endtask

   // Sampled at negedge: checks this cycle's outputs and advances the reference model.
   task automatic sample_and_model();
      int rl, sz, len;
      bit empty, nb, fill, tmo;
      for (int i = 0; i < 2; i++) begin
         rl    = i + 1;
         sz    = fq[i].size();
         empty = (sz == 0);
         s_busy[i] = bz[i];
         p_v[i] = 1'b0;
         if (!rst_n) begin
            chk($sformatf("rst_outputs[%0d]", i), {rd_en[i], ov[i], of[i], ol[i], bz[i], od[i]}, '0);
            m_busy[i] = 0; m_freq[i] = 0; m_tmo[i] = 0; m_out[i] = 0;
            m_rem[i] = 0; m_rdleft[i] = 0; s_v[i] = 0;
            eq[i].delete();
            continue;
         end
         chk($sformatf("busy[%0d]", i), bz[i], m_busy[i]);
         nb = m_busy[i];
         if (rd_en[i]) begin
            chk($sformatf("rd_en_legal[%0d]", i), {m_busy[i], m_rdleft[i] != 0, !empty}, 3'b111);
            if (m_busy[i] && m_rdleft[i] != 0 && !empty) begin
               p_w[i] = fq[i].pop_front();
               p_v[i] = 1'b1;
               m_rdleft[i]--;
               m_out[i]++;
               chk($sformatf("credit_ovf[%0d]", i), m_out[i] > 4, 0);
            end
         end
         if (ov[i]) begin
            if (eq[i].size() == 0) chk($sformatf("spurious_valid[%0d]", i), ov[i], 0);
            else begin
               if (!m_seen[i]) begin
                  chk($sformatf("first_latency[%0d]", i), cyc - m_trig[i], rl + 2);
                  m_seen[i] = 1'b1;
               end
               chk($sformatf("out_data[%0d]", i), od[i], eq[i][0].d);
               chk($sformatf("out_first[%0d]", i), of[i], eq[i][0].f);
               chk($sformatf("out_last[%0d]", i), ol[i], eq[i][0].l);
               if (out_ready) begin
                  void'(eq[i].pop_front());
                  m_out[i]--; m_rem[i]--; pops[i]++;
                  if (m_rem[i] == 0) nb = 1'b0;
               end
            end
         end else if (gap_mode && m_busy[i] && m_seen[i] && m_rem[i] > 0) begin
            chk($sformatf("gap[%0d]", i), ov[i], 1);
         end
         if (!m_busy[i]) begin
            fill = (sz >= BL);
            tmo  = ((m_tmo[i] == TO) || m_freq[i]) && !empty;
            if (fill || tmo) begin
               len = (sz < BL) ? sz : BL;
               for (int k = 0; k < len; k++)
                  eq[i].push_back('{d: fq[i][k], f: (k == 0), l: (k == len - 1)});
               nb = 1'b1; m_rdleft[i] = len; m_rem[i] = len; m_trig[i] = cyc;
               m_seen[i] = 1'b0; m_tmo[i] = 0; m_freq[i] = 1'b0;
            end else begin
               m_tmo[i]  = empty ? 0 : ((m_tmo[i] < TO) ? m_tmo[i] + 1 : TO);
               m_freq[i] = empty ? 1'b0 : (m_freq[i] | flush);
            end
         end else begin
            if (empty) m_tmo[i] = 0;
            m_freq[i] = m_freq[i] | flush;
         end
         m_busy[i] = nb;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      sample_and_model();
      @(posedge clk);
      #1;
      cyc++;
      if (p_v[0]) rd_data[0] = p_w[0];
      if (s_v[1]) rd_data[1] = s_w[1];
      s_v[1] = p_v[1];
      s_w[1] = p_w[1];
      drive_fifo();
   endtask

   task automatic wait_busy(input int exp_dly, input string tag);
      int e, got;
      e = cyc; got = -1;
      for (int n = 0; n < 60; n++) begin
         cycle();
         flush = 1'b0;
         if (s_busy[1]) begin
            got = cyc - 1 - e;
            chk({tag, "_lat1"}, s_busy[0], 1);
            break;
         end
      end
      chk(tag, got, exp_dly);
   endtask

   task automatic drain(input string tag);
      bit done;
      done = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 400; n++) begin
         cycle();
         if (!m_busy[0] && !m_busy[1] && !s_busy[0] && !s_busy[1] && eq[0].size() == 0 &&
             eq[1].size() == 0 && fq[0].size() == 0 && fq[1].size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      chk(tag, done, 1);
      repeat (2) cycle();
   endtask

   initial begin
      int base;
      vectors = 0; miscompares = 0; cyc = 0; nxt_word = 16'h0001; gap_mode = 1'b1;
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rd_data[i] = '0; pops[i] = 0; p_v[i] = 0; s_v[i] = 0; m_busy[i] = 0;
         m_tmo[i] = 0; m_freq[i] = 0; m_out[i] = 0; m_rem[i] = 0; m_rdleft[i] = 0;
      end
      drive_fifo();
      #1;
      for (int i = 0; i < 2; i++)
         chk($sformatf("reset_state[%0d]", i), {rd_en[i], ov[i], of[i], ol[i], bz[i], od[i]}, '0);
      repeat (3) cycle();
      rst_n = 1'b1;
      repeat (2) cycle();

      // Fill trigger: one word per cycle, 0x0001..0x0008
      for (int k = 0; k < 8; k++) begin
         push_word(nxt_word); nxt_word++;
         cycle();
      end
      drain("fill_drain");

      // Idle timeout with a 3-word partial burst
      for (int k = 0; k < 3; k++) begin push_word(nxt_word); nxt_word++; end
      wait_busy(TO + 1, "timeout_start");
      drain("timeout_drain");

      // Flush with 5 words present
      for (int k = 0; k < 5; k++) begin push_word(nxt_word); nxt_word++; end
      repeat (2) cycle();
      flush = 1'b1;
      wait_busy(2, "flush_start");
      drain("flush_drain");

      // Flush with the FIFO empty is dropped; a later single word waits for the timeout
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      repeat (5) cycle();
      chk("flush_empty_idle", {s_busy[0], s_busy[1]}, 2'b00);
      push_word(nxt_word); nxt_word++;
      wait_busy(TO + 1, "flush_dropped");
      drain("single_drain");

      // Backpressure over a 16-word load
      gap_mode = 1'b0;
      for (int k = 0; k < 16; k++) begin push_word(nxt_word); nxt_word++; end
      for (int n = 0; n < 120; n++) begin
         out_ready = 1'($urandom_range(0, 1));
         cycle();
      end
      drain("backpressure_drain");

      // Reset after the third output word of the READ_LATENCY=2 instance
      gap_mode = 1'b1;
      for (int k = 0; k < 16; k++) begin push_word(nxt_word); nxt_word++; end
      base = pops[1];
      for (int n = 0; n < 40 && pops[1] < base + 3; n++) cycle();
      chk("third_word_seen", pops[1] >= base + 3, 1);
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++)
         chk($sformatf("async_reset[%0d]", i), {rd_en[i], ov[i], of[i], ol[i], bz[i], od[i]}, '0);
      repeat (2) cycle();
      rst_n = 1'b1;
      drain("post_reset_drain");

      // Mixed random traffic, flushes and backpressure
      gap_mode = 1'b0;
      for (int n = 0; n < 300; n++) begin
         out_ready = 1'($urandom_range(0, 1));
         flush = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 2) == 0) begin push_word(nxt_word); nxt_word++; end
         cycle();
      end
      flush = 1'b0;
      drain("random_drain");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
